gelato_l2_responder: RTL and testbench
======================================

# gelato_l2_responder

Responder end of the SM-to-L2 cache request interface: accepts instruction- and data-cache requests from all SM request ports and arbitrates among them round-robin. It forwards one transaction at a time to a single downstream memory port and returns the response to the originating requester. It sits at the top level between the `gelato_sm` array and the L2/memory backend.

## Interface
- `NUM_REQ`, 8, number of requester ports (2 × `SM_NUM`: inst + data per SM); index `2*i` = SM i inst, `2*i+1` = SM i data
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, read/write data width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `rdy`  in  1  global enable; low freezes all state
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  one-hot accept strobe
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wen`  in  NUM_REQ  1 = write, 0 = read
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `rsp_valid`  out  NUM_REQ  one-hot response strobe, single cycle
- `rsp_data`  out  DATA_WIDTH  response data, shared by all requesters
- `mem_req_valid`  out  1  downstream request valid
- `mem_req_ready`  in  1  downstream accept
- `mem_addr` / `mem_wen` / `mem_wdata`  out  ADDR_WIDTH / 1 / DATA_WIDTH  downstream request fields
- `mem_rsp_valid`  in  1  downstream response (read data or write ack)
- `mem_rsp_data`  in  DATA_WIDTH  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, grant = first set bit at or after `rr_ptr`, searching upward with wrap from `NUM_REQ-1` to 0.
  - Same cycle: `req_ready[grant]=1`, which is combinational from `req_valid`.
  - Latch addr/wen/wdata/grant.
  - `rr_ptr <= (grant+1) mod NUM_REQ`; go to ISSUE.
- ISSUE: `mem_req_valid=1` with latched fields. On `mem_req_ready` go to WAIT. Once raised, valid and fields stay stable until accepted.
- WAIT: on `mem_rsp_valid`, latch `mem_rsp_data` and go to RESP.
- RESP: `rsp_valid[grant]=1` for exactly one cycle; `rsp_data` = latched data (writes carry the latched ack data, which is don't-care). Go to IDLE.
- Responses have no backpressure; requesters must sink `rsp_valid`.
- Requesters hold `req_valid` and their fields stable until `req_ready`.
- `req_ready` is 0 in every state except IDLE.
- `mem_rsp_valid` outside WAIT is ignored.
- Only one transaction is outstanding.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `mem_req_valid` 0, `mem_addr`/`mem_wen`/`mem_wdata` 0, grant 0.
- Minimum latency, request accepted at cycle T:
  - `mem_req_valid` at T+1.
  - Accepted at T+1 gives WAIT at T+2.
  - `mem_rsp_valid` at T+2 gives `rsp_valid` at T+3.
  - Next grant possible at T+4.
- `rdy=0`: no state, pointer or register changes. `req_ready` is forced 0; other outputs hold their registered values. `mem_rsp_valid`/`mem_req_ready` arriving while `rdy=0` are ignored; the backend must hold them.
- Reset asserted mid-transaction: the transaction is dropped, no `rsp_valid` is issued, and all reset values apply immediately (asynchronous).
- All requesters valid continuously: grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- The grant index register is `$clog2(NUM_REQ)` bits. Pointer increment wraps modulo `NUM_REQ`, which need not be a power of 2.

## Structure
- Package `gelato_l2_pkg`:
  - `l2_state_e` enum (IDLE, ISSUE, WAIT, RESP)
  - `l2_req_t` struct {addr, wen, wdata}
  - width constants
- Sub-module `gelato_rr_arbiter`:
  - Parameter `NUM_REQ`; inputs request vector and pointer.
  - Outputs one-hot grant, grant index and any-valid.
  - Purely combinational; reused elsewhere.
- The top holds the FSM, latches and the pointer register.

## Test plan
- Single read: requester 3 valid, addr 0x100; memory accepts immediately and returns 0xDEADBEEF one cycle later. Expect `req_ready[3]` at T, `mem_req_valid` with addr 0x100 at T+1, `rsp_valid=8'b0000_1000` and `rsp_data=0xDEADBEEF` at T+3.
- Write: requester 0 writes 0x55 to 0x40. Expect `mem_wen=1`, `mem_wdata=0x55`, then one `rsp_valid[0]` pulse after the ack.
- Fairness: all 8 requesters valid continuously. Grant order is 0..7 then 0, and `rr_ptr` wraps 7→0.
- Backpressure: `mem_req_ready` low for 5 cycles. `mem_req_valid` and fields stay stable; a spurious `mem_rsp_valid` during ISSUE is ignored.
- Stall: `rdy` low for 3 cycles during WAIT with `mem_rsp_valid` high only while `rdy=0`. No state change occurs; the response completes after `rdy` rises and the backend re-presents the data.
- Reset mid-WAIT: assert `rst`. Outputs go to 0 at once; after release, requester 0 is granted first.

Source files
------------

// File: rtl/gelato_l2_pkg.sv
// Shared types and default widths for the SM-to-L2 request responder.
package gelato_l2_pkg;

  localparam int L2_NUM_REQ = 8;
  localparam int L2_ADDR_W  = 32;
  localparam int L2_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } l2_state_e;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic                 wen;
    logic [L2_DATA_W-1:0] wdata;
  } l2_req_t;

  // Callers keep idx below 2*n, so one conditional subtract is a full modulo.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module gelato_rr_arbiter
  import gelato_l2_pkg::*;
#(
  parameter int NUM_REQ = 8,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    idx       = '0;
    any_valid = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'(rr_wrap(int'(ptr) + i, NUM_REQ));
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/gelato_l2_responder.sv
// Arbitrates SM inst/data requests onto one memory port, one transaction in flight,
// and routes each response back to the requester that issued it.
module gelato_l2_responder
  import gelato_l2_pkg::*;
#(
  parameter int NUM_REQ    = L2_NUM_REQ,
  parameter int ADDR_WIDTH = L2_ADDR_W,
  parameter int DATA_WIDTH = L2_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_wen,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_wen,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  l2_state_e             state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  l2_req_t               req_q, req_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  l2_req_t               sel_req;

  gelato_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .any_valid (arb_any)
  );

  always_comb begin
    sel_req.addr  = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_req.wen   = req_wen[arb_idx];
    sel_req.wdata = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // With rdy low every *_d equals its *_q, which freezes the whole block.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    req_d      = req_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          req_ready = rst ? '0 : arb_gnt;
          if (arb_any) begin
            req_d    = sel_req;
            grant_d  = arb_idx;
            rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            state_d  = ISSUE;
          end
        end
        ISSUE: if (mem_req_ready) state_d = WAIT;
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data_d = mem_rsp_data;
            state_d    = RESP;
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      req_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      req_q      <= req_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi));
  end

  assign rsp_data      = rsp_data_q;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = req_q.addr;
  assign mem_wen       = req_q.wen;
  assign mem_wdata     = req_q.wdata;

endmodule

// File: tb/tb_gelato_l2_responder.sv
// Self-checking bench for gelato_l2_responder: directed scenarios plus randomized traffic.
module tb_gelato_l2_responder;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_wen = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [DW-1:0]     mem_rsp_data = '0;

  gelato_l2_responder dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_ptr = 0;

  logic [AW-1:0] tb_addr [N];
  logic          tb_wen  [N];
  logic [DW-1:0] tb_wdata[N];

  logic [N-1:0]  obs_ready, obs_rsp_valid, obs_rsp_after;
  logic          obs_mem_valid, obs_stable, obs_wen;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rsp_data;

  // Reference: round-robin means first requester at or after the pointer, wrapping.
  function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (mask[j[2:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g[2:0]] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = tb_addr[k];
      req_wen[k]            = tb_wen[k];
      req_wdata[k*DW +: DW] = tb_wdata[k];
    end
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < N; k++) begin
      tb_addr[k]  = $urandom;
      tb_wen[k]   = 1'($urandom_range(0, 1));
      tb_wdata[k] = $urandom;
    end
  endtask

  // Runs one transaction through the protocol and records what the DUT showed.
  task automatic do_txn(input logic [N-1:0] mask, input int acc_dly, input int rsp_dly,
                        input logic [DW-1:0] mdata, input bit spurious, input int stall);
    drive_fields();
    req_valid = mask;
    #1;
    obs_ready  = req_ready;
    obs_stable = 1'b1;
    step();
    req_valid = mask & ~obs_ready;
    #1;
    obs_mem_valid = mem_req_valid;
    obs_addr      = mem_addr;
    obs_wen       = mem_wen;
    obs_wdata     = mem_wdata;
    for (int i = 0; i < acc_dly; i++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = spurious && (i == 1);
      mem_rsp_data  = ~mdata;
      #1;
      if (mem_req_valid !== 1'b1 || mem_addr !== obs_addr || mem_wen !== obs_wen ||
          mem_wdata !== obs_wdata || req_ready !== '0) obs_stable = 1'b0;
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      rdy           = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = ~mdata;
      #1;
      if (rsp_valid !== '0 || mem_req_valid !== 1'b0 || req_ready !== '0) obs_stable = 1'b0;
      step();
    end
    rdy           = 1'b1;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      #1;
      if (rsp_valid !== '0 || mem_req_valid !== 1'b0) obs_stable = 1'b0;
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = mdata;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    if (req_ready !== '0) obs_stable = 1'b0;
    obs_rsp_valid = rsp_valid;
    obs_rsp_data  = rsp_data;
    step();
    #1;
    obs_rsp_after = rsp_valid;
    req_valid = '0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    step();
    step();
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid got=%h exp=0", rsp_valid); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    n_vec++; if ({mem_addr, mem_wen, mem_wdata} !== '0) begin n_err++;
      $display("FAIL reset_mem_fields got addr=%h wen=%b wdata=%h exp=0", mem_addr, mem_wen, mem_wdata); end
    req_valid = '0;
    #2 rst = 1'b0;
    step();
    model_ptr = 0;
    $display("test_reset done");
  endtask

  task automatic test_fairness();
    for (int i = 0; i < N + 1; i++) begin
      logic [DW-1:0] d;
      int g;
      g = i % N;
      d = $urandom;
      randomize_fields();
      do_txn('1, 0, 0, d, 1'b0, 0);
      n_vec++; if (obs_ready !== onehot(g)) begin n_err++; $display("FAIL fair_grant[%0d] got=%b exp=%b", i, obs_ready, onehot(g)); end
      n_vec++; if (obs_mem_valid !== 1'b1 || obs_addr !== tb_addr[g]) begin n_err++;
        $display("FAIL fair_addr[%0d] got v=%b a=%h exp v=1 a=%h", i, obs_mem_valid, obs_addr, tb_addr[g]); end
      n_vec++; if (obs_rsp_valid !== onehot(g) || obs_rsp_data !== d) begin n_err++;
        $display("FAIL fair_rsp[%0d] got v=%b d=%h exp v=%b d=%h", i, obs_rsp_valid, obs_rsp_data, onehot(g), d); end
      model_ptr = (g + 1) % N;
      $display("fairness txn %0d grant=%0d", i, g);
    end
  endtask

  task automatic test_single_read();
    randomize_fields();
    tb_addr[3] = 32'h100;
    tb_wen[3]  = 1'b0;
    do_txn(8'h08, 0, 0, 32'hDEADBEEF, 1'b0, 0);
    n_vec++; if (obs_ready !== 8'h08) begin n_err++; $display("FAIL read_ready got=%b exp=00001000", obs_ready); end
    n_vec++; if (obs_mem_valid !== 1'b1 || obs_addr !== 32'h100 || obs_wen !== 1'b0) begin n_err++;
      $display("FAIL read_mem got v=%b a=%h w=%b exp v=1 a=100 w=0", obs_mem_valid, obs_addr, obs_wen); end
    n_vec++; if (obs_rsp_valid !== 8'b0000_1000) begin n_err++; $display("FAIL read_rsp_valid got=%b exp=00001000", obs_rsp_valid); end
    n_vec++; if (obs_rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rsp_data got=%h exp=deadbeef", obs_rsp_data); end
    n_vec++; if (obs_rsp_after !== '0) begin n_err++; $display("FAIL read_rsp_pulse got=%b exp=0", obs_rsp_after); end
    model_ptr = 4;
    $display("single read txn addr=100 data=%h", obs_rsp_data);
  endtask

  task automatic test_write();
    logic [DW-1:0] ack;
    ack = $urandom;
    randomize_fields();
    tb_addr[0]  = 32'h40;
    tb_wen[0]   = 1'b1;
    tb_wdata[0] = 32'h55;
    do_txn(8'h01, 0, 2, ack, 1'b0, 0);
    n_vec++; if (obs_ready !== 8'h01) begin n_err++; $display("FAIL write_ready got=%b exp=00000001", obs_ready); end
    n_vec++; if (obs_addr !== 32'h40 || obs_wen !== 1'b1 || obs_wdata !== 32'h55) begin n_err++;
      $display("FAIL write_mem got a=%h w=%b d=%h exp a=40 w=1 d=55", obs_addr, obs_wen, obs_wdata); end
    n_vec++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL write_wait_quiet got=%b exp=1", obs_stable); end
    n_vec++; if (obs_rsp_valid !== 8'h01 || obs_rsp_after !== '0) begin n_err++;
      $display("FAIL write_rsp got=%b then %b exp=00000001 then 0", obs_rsp_valid, obs_rsp_after); end
    model_ptr = 1;
    $display("write txn addr=40 wdata=55");
  endtask

  task automatic test_backpressure();
    logic [N-1:0] mask;
    logic [DW-1:0] d;
    int g;
    mask = 8'h24;
    d = $urandom;
    randomize_fields();
    g = model_grant(mask, model_ptr);
    do_txn(mask, 5, 1, d, 1'b1, 0);
    n_vec++; if (obs_ready !== onehot(g)) begin n_err++; $display("FAIL bp_ready got=%b exp=%b", obs_ready, onehot(g)); end
    n_vec++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL bp_stable got=%b exp=1", obs_stable); end
    n_vec++; if ({obs_addr, obs_wen, obs_wdata} !== {tb_addr[g], tb_wen[g], tb_wdata[g]}) begin n_err++;
      $display("FAIL bp_fields got a=%h w=%b d=%h exp a=%h w=%b d=%h", obs_addr, obs_wen, obs_wdata, tb_addr[g], tb_wen[g], tb_wdata[g]); end
    n_vec++; if (obs_rsp_valid !== onehot(g) || obs_rsp_data !== d) begin n_err++;
      $display("FAIL bp_rsp got v=%b d=%h exp v=%b d=%h", obs_rsp_valid, obs_rsp_data, onehot(g), d); end
    model_ptr = (g + 1) % N;
    $display("backpressure txn grant=%0d", g);
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    d = $urandom;
    randomize_fields();
    drive_fields();
    rdy = 1'b0;
    req_valid = 8'h80;
    #1;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL stall_idle_ready got=%b exp=0", req_ready); end
    step();
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle_hold got=%b exp=0", mem_req_valid); end
    rdy = 1'b1;
    req_valid = '0;
    do_txn(8'h80, 0, 1, d, 1'b0, 3);
    n_vec++; if (obs_ready !== 8'h80) begin n_err++; $display("FAIL stall_ready got=%b exp=10000000", obs_ready); end
    n_vec++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL stall_frozen got=%b exp=1", obs_stable); end
    n_vec++; if (obs_rsp_valid !== 8'h80 || obs_rsp_data !== d) begin n_err++;
      $display("FAIL stall_rsp got v=%b d=%h exp v=10000000 d=%h", obs_rsp_valid, obs_rsp_data, d); end
    model_ptr = 0;
    $display("stall txn data=%h", d);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] mask;
      logic [DW-1:0] d;
      int g, acc, rd, st;
      bit sp;
      mask = N'($urandom_range(1, 255));
      acc  = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      st   = $urandom_range(0, 2);
      sp   = (acc >= 2) && ($urandom_range(0, 1) == 1);
      d    = $urandom;
      randomize_fields();
      g = model_grant(mask, model_ptr);
      do_txn(mask, acc, rd, d, sp, st);
      n_vec++; if (obs_ready !== onehot(g)) begin n_err++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, obs_ready, onehot(g)); end
      n_vec++; if ({obs_mem_valid, obs_addr, obs_wen, obs_wdata} !== {1'b1, tb_addr[g], tb_wen[g], tb_wdata[g]}) begin n_err++;
        $display("FAIL rnd_mem[%0d] got v=%b a=%h w=%b d=%h exp a=%h w=%b d=%h", i, obs_mem_valid, obs_addr, obs_wen, obs_wdata, tb_addr[g], tb_wen[g], tb_wdata[g]); end
      n_vec++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL rnd_stable[%0d] got=%b exp=1", i, obs_stable); end
      n_vec++; if (obs_rsp_valid !== onehot(g) || obs_rsp_data !== d || obs_rsp_after !== '0) begin n_err++;
        $display("FAIL rnd_rsp[%0d] got v=%b d=%h after=%b exp v=%b d=%h after=0", i, obs_rsp_valid, obs_rsp_data, obs_rsp_after, onehot(g), d); end
      model_ptr = (g + 1) % N;
      $display("random txn %0d mask=%b grant=%0d acc=%0d rsp=%0d stall=%0d", i, mask, g, acc, rd, st);
    end
  endtask

  task automatic test_reset_mid_wait();
    randomize_fields();
    drive_fields();
    req_valid = 8'h20;
    step();
    req_valid = '0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (mem_req_valid !== 1'b0 || {mem_addr, mem_wen, mem_wdata} !== '0) begin n_err++;
      $display("FAIL rstw_mem got v=%b a=%h exp 0", mem_req_valid, mem_addr); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL rstw_rsp_data got=%h exp=0", rsp_data); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = $urandom;
    step();
    rst = 1'b0;
    step();
    mem_rsp_valid = 1'b0;
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rstw_dropped got=%b exp=0", rsp_valid); end
    step();
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rstw_dropped2 got=%b exp=0", rsp_valid); end
    model_ptr = 0;
    randomize_fields();
    do_txn('1, 0, 0, 32'h1234_5678, 1'b0, 0);
    n_vec++; if (obs_ready !== 8'h01) begin n_err++; $display("FAIL rstw_first_grant got=%b exp=00000001", obs_ready); end
    n_vec++; if (obs_rsp_valid !== 8'h01 || obs_rsp_data !== 32'h1234_5678) begin n_err++;
      $display("FAIL rstw_rsp got v=%b d=%h exp v=00000001 d=12345678", obs_rsp_valid, obs_rsp_data); end
    $display("reset mid-wait txn, first grant after release=%b", obs_ready);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_write();
    test_backpressure();
    test_stall();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
